// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution weight-address generator.
//   conv_state_e  - generator FSM states (IDLE/RUN/DONE)
//   *_DEF         - default ADDR_W / VEC_LEN / CI_UNIT values
//   grp_words()   - words in one output-channel group for a given cfg_ci
package conv_pkg;

  localparam int unsigned ADDR_W_DEF  = 26;
  localparam int unsigned VEC_LEN_DEF = 16;
  localparam int unsigned CI_UNIT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  // GRP = (cfg_ci + 1) * CI_UNIT * VEC_LEN
  function automatic int unsigned grp_words(input int unsigned ci,
                                            input int unsigned ci_unit,
                                            input int unsigned vec_len);
    return (ci + 1) * ci_unit * vec_len;
  endfunction

endpackage

// File: rtl/conv_nest_cnt.sv
// conv_nest_cnt: i/m/p/g nested loop counter for the weight-address walk.
// Ports:
//   clk_i, rst_i  - clock, synchronous active-high reset
//   clr_i         - clear all counters (start of a new job)
//   en_i          - advance one beat (transfer strobe)
//   m_max_i       - last vector index of a pixel sweep (M-1)
//   p_max_i       - last pixel index of a group (cfg_pix)
//   g_max_i       - last group index (cfg_co)
//   pix_end_o     - current beat ends a pixel sweep (i and m at max)
//   grp_end_o     - current beat ends a group (pixel end and p at max)
//   all_end_o     - current beat is the final beat of the job
module conv_nest_cnt
  import conv_pkg::*;
#(
  parameter int unsigned VEC_LEN = VEC_LEN_DEF,
  parameter int unsigned M_W     = 5,
  parameter int unsigned P_W     = 9,
  parameter int unsigned G_W     = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  input  logic           en_i,
  input  logic [M_W-1:0] m_max_i,
  input  logic [P_W-1:0] p_max_i,
  input  logic [G_W-1:0] g_max_i,
  output logic           pix_end_o,
  output logic           grp_end_o,
  output logic           all_end_o
);

  localparam int unsigned I_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  logic [I_W-1:0] i_q, i_d;
  logic [M_W-1:0] m_q, m_d;
  logic [P_W-1:0] p_q, p_d;
  logic [G_W-1:0] g_q, g_d;

  logic i_end, m_end, p_end, g_end;

  // Each wrap flag already includes all inner wraps.
  assign i_end = (i_q == I_W'(VEC_LEN - 1));
  assign m_end = i_end && (m_q == m_max_i);
  assign p_end = m_end && (p_q == p_max_i);
  assign g_end = p_end && (g_q == g_max_i);

  assign pix_end_o = m_end;
  assign grp_end_o = p_end;
  assign all_end_o = g_end;

  always_comb begin
    i_d = i_q;
    m_d = m_q;
    p_d = p_q;
    g_d = g_q;
    if (clr_i) begin
      i_d = '0;
      m_d = '0;
      p_d = '0;
      g_d = '0;
    end else if (en_i) begin
      i_d = i_end ? '0 : i_q + I_W'(1);
      if (i_end) m_d = m_end ? '0 : m_q + M_W'(1);
      if (m_end) p_d = p_end ? '0 : p_q + P_W'(1);
      if (p_end) g_d = g_end ? '0 : g_q + G_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_q <= '0;
      m_q <= '0;
      p_q <= '0;
      g_q <= '0;
    end else begin
      i_q <= i_d;
      m_q <= m_d;
      p_q <= p_d;
      g_q <= g_d;
    end
  end

endmodule

// File: rtl/conv_waddr_gen.sv
// conv_waddr_gen: weight-address generator for the convolution kernel.
// Walks base + g*GRP + m*VEC_LEN + i for every pixel of every output group,
// presented as a valid/ready stream to the weight SRAM read port.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start_conv          - start pulse (IDLE only); latches cfg_*
//   end_conv            - abort request while running
//   cfg_ci/co/pix/base  - job configuration
//   waddr/_valid/_ready - address stream; waddr_last marks pixel end
//   busy                - job running
//   done                - one-cycle completion pulse
//   stall_cnt           - (CONV_WADDR_STALL_CNT_EN only) stalled RUN cycles
// Optional feature macro: CONV_WADDR_STALL_CNT_EN
module conv_waddr_gen
  import conv_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned VEC_LEN = VEC_LEN_DEF,
  parameter int unsigned CI_UNIT = CI_UNIT_DEF,
  parameter int unsigned CFG_W   = 2,
  parameter int unsigned PIX_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_conv,
  input  logic              end_conv,
  input  logic [CFG_W-1:0]  cfg_ci,
  input  logic [CFG_W-1:0]  cfg_co,
  input  logic [PIX_W-1:0]  cfg_pix,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic [ADDR_W-1:0] waddr,
  output logic              waddr_valid,
  input  logic              waddr_ready,
  output logic              waddr_last,
  output logic              busy,
`ifdef CONV_WADDR_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              done
);

  localparam int unsigned M_MAX = (2 ** CFG_W) * CI_UNIT;
  localparam int unsigned M_W   = (M_MAX > 1) ? $clog2(M_MAX) : 1;

  conv_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] gbase_q, gbase_d;
  logic [ADDR_W-1:0] grp_q, grp_d;
  logic [M_W-1:0]    m_max_q, m_max_d;
  logic [PIX_W-1:0]  p_max_q, p_max_d;
  logic [CFG_W-1:0]  g_max_q, g_max_d;

  logic run, start, xfer;
  logic pix_end, grp_end, all_end;

  assign run   = (state_q == ST_RUN);
  assign start = (state_q == ST_IDLE) && start_conv;
  assign xfer  = run && waddr_ready;

  conv_nest_cnt #(
    .VEC_LEN (VEC_LEN),
    .M_W     (M_W),
    .P_W     (PIX_W),
    .G_W     (CFG_W)
  ) u_cnt (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (start),
    .en_i      (xfer && !end_conv),
    .m_max_i   (m_max_q),
    .p_max_i   (p_max_q),
    .g_max_i   (g_max_q),
    .pix_end_o (pix_end),
    .grp_end_o (grp_end),
    .all_end_o (all_end)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    gbase_d = gbase_q;
    grp_d   = grp_q;
    m_max_d = m_max_q;
    p_max_d = p_max_q;
    g_max_d = g_max_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_conv) begin
          state_d = ST_RUN;
          addr_d  = cfg_base;
          gbase_d = cfg_base;
          grp_d   = ADDR_W'(grp_words(32'(cfg_ci), CI_UNIT, VEC_LEN));
          m_max_d = M_W'(32'(cfg_ci) * CI_UNIT + CI_UNIT - 1);
          p_max_d = cfg_pix;
          g_max_d = cfg_co;
        end
      end
      ST_RUN: begin
        if (end_conv) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          if (pix_end) begin
            // Rewind to the group base between pixels; step to the next
            // group base after the group's last pixel.
            if (grp_end) begin
              gbase_d = gbase_q + grp_q;
              addr_d  = gbase_q + grp_q;
            end else begin
              addr_d  = gbase_q;
            end
            if (all_end) state_d = ST_DONE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      gbase_q <= '0;
      grp_q   <= '0;
      m_max_q <= '0;
      p_max_q <= '0;
      g_max_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      gbase_q <= gbase_d;
      grp_q   <= grp_d;
      m_max_q <= m_max_d;
      p_max_q <= p_max_d;
      g_max_q <= g_max_d;
    end
  end

  assign waddr       = addr_q;
  assign waddr_valid = run;
  assign waddr_last  = run && pix_end;
  assign busy        = run;
  assign done        = (state_q == ST_DONE);

`ifdef CONV_WADDR_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start) begin
      stall_d = '0;
    end else if (run && !waddr_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_waddr_gen.sv
// tb_conv_waddr_gen: self-checking bench for conv_waddr_gen.
// Table of directed configurations plus randomized ones, each checked beat by
// beat against an address list built from the nested-loop address formula.
module tb_conv_waddr_gen;

  localparam int unsigned ADDR_W  = 26;
  localparam int unsigned VEC_LEN = 16;
  localparam int unsigned CI_UNIT = 8;
  localparam int unsigned CFG_W   = 2;
  localparam int unsigned PIX_W   = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_conv;
  logic              end_conv;
  logic [CFG_W-1:0]  cfg_ci;
  logic [CFG_W-1:0]  cfg_co;
  logic [PIX_W-1:0]  cfg_pix;
  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W-1:0] waddr;
  logic              waddr_valid;
  logic              waddr_ready;
  logic              waddr_last;
  logic              busy;
  logic              done;
`ifdef CONV_WADDR_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  conv_waddr_gen #(
    .ADDR_W  (ADDR_W),
    .VEC_LEN (VEC_LEN),
    .CI_UNIT (CI_UNIT),
    .CFG_W   (CFG_W),
    .PIX_W   (PIX_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_conv  (start_conv),
    .end_conv    (end_conv),
    .cfg_ci      (cfg_ci),
    .cfg_co      (cfg_co),
    .cfg_pix     (cfg_pix),
    .cfg_base    (cfg_base),
    .waddr       (waddr),
    .waddr_valid (waddr_valid),
    .waddr_ready (waddr_ready),
    .waddr_last  (waddr_last),
    .busy        (busy),
`ifdef CONV_WADDR_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CFG_W-1:0]  ci;
    logic [CFG_W-1:0]  co;
    logic [PIX_W-1:0]  pix;
    logic [ADDR_W-1:0] base;
    int                stall_beat;
    int                stall_len;
    int                start_beat;
    int                exp_beats;
    logic [ADDR_W-1:0] exp_last_addr;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  bit                exp_last[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: enumerate the four nested loops directly from the formula.
  task automatic build_model(input int unsigned ci, input int unsigned co,
                             input int unsigned pix, input logic [ADDR_W-1:0] base);
    longint unsigned grp, mm, a;
    logic [ADDR_W-1:0] at;
    exp_addr.delete();
    exp_last.delete();
    mm  = longint'(ci + 1) * CI_UNIT;
    grp = mm * VEC_LEN;
    for (int unsigned g = 0; g <= co; g++)
      for (int unsigned p = 0; p <= pix; p++)
        for (longint unsigned m = 0; m < mm; m++)
          for (int unsigned i = 0; i < VEC_LEN; i++) begin
            a  = longint'(base) + g * grp + m * VEC_LEN + i;
            at = a[ADDR_W-1:0];
            exp_addr.push_back(at);
            exp_last.push_back((m == mm - 1) && (i == VEC_LEN - 1));
          end
  endtask

  task automatic run_cfg(input vec_t v, input bit rnd, output int beats,
                         output logic [ADDR_W-1:0] last_a);
    int idx, cyc, budget, stalls_left, tb_stall;
    bit stall_started;
    build_model(32'(v.ci), 32'(v.co), 32'(v.pix), v.base);
    idx = 0; cyc = 0; stalls_left = 0; tb_stall = 0; stall_started = 0;
    beats = 0; last_a = '0;
    budget = exp_addr.size() * 8 + 50;
    cfg_ci = v.ci; cfg_co = v.co; cfg_pix = v.pix; cfg_base = v.base;
    waddr_ready = 1'b1; end_conv = 1'b0; start_conv = 1'b1;
    @(negedge clk);
    start_conv = 1'b0;
    // Only the latched configuration may matter from here on.
    cfg_ci = CFG_W'($urandom); cfg_co = CFG_W'($urandom);
    cfg_pix = PIX_W'($urandom); cfg_base = ADDR_W'($urandom);
    while (idx < exp_addr.size() && cyc < budget) begin
      chk("run_valid", 64'(waddr_valid), 64'(1));
      chk("run_busy", 64'(busy), 64'(1));
      chk("run_done", 64'(done), 64'(0));
      if (v.stall_beat >= 0 && idx == v.stall_beat && !stall_started) begin
        stall_started = 1;
        stalls_left   = v.stall_len;
      end
      if (stalls_left > 0) begin
        waddr_ready = 1'b0;
        stalls_left--;
        chk("stall_hold", 64'(waddr), 64'(exp_addr[idx]));
      end else if (rnd) begin
        waddr_ready = ($urandom_range(0, 3) != 0);
      end else begin
        waddr_ready = 1'b1;
      end
      if (waddr_valid && !waddr_ready) tb_stall++;
      start_conv = (idx == v.start_beat);
      if (waddr_valid && waddr_ready) begin
        chk("addr", 64'(waddr), 64'(exp_addr[idx]));
        chk("last", 64'(waddr_last), 64'(exp_last[idx]));
        last_a = waddr;
        idx++;
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    start_conv = 1'b0;
    waddr_ready = 1'b1;
    if (cyc >= budget) begin
      checks++;
      errors++;
      $display("FAIL timeout beats=%0d required=%0d", idx, exp_addr.size());
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    chk("done_pulse", 64'(done), 64'(1));
    chk("done_valid", 64'(waddr_valid), 64'(0));
    chk("done_busy", 64'(busy), 64'(0));
    chk("done_last", 64'(waddr_last), 64'(0));
`ifdef CONV_WADDR_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(tb_stall));
    if (!rnd && v.stall_beat >= 0) chk("stall_cnt_len", 64'(stall_cnt), 64'(v.stall_len));
`endif
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("idle_valid", 64'(waddr_valid), 64'(0));
  endtask

  vec_t tbl[5];

  initial begin
    int beats;
    logic [ADDR_W-1:0] last_a;
    vec_t rv;

    tbl[0] = '{2'd0, 2'd1, 9'd1, 26'h0000100, -1, 0, 100, 512,  26'h00001FF};
    tbl[1] = '{2'd0, 2'd1, 9'd1, 26'h0000100, 20, 5, -1,  512,  26'h00001FF};
    tbl[2] = '{2'd1, 2'd0, 9'd0, 26'h3FFFFF0, -1, 0, -1,  256,  26'h00000EF};
    tbl[3] = '{2'd3, 2'd0, 9'd2, 26'h3FFFE00, 7,  3, 600, 1536, 26'h3FFFFFF};
    tbl[4] = '{2'd0, 2'd3, 9'd0, 26'h0000000, -1, 0, -1,  512,  26'h00001FF};

    rst = 1'b1; start_conv = 1'b0; end_conv = 1'b0; waddr_ready = 1'b0;
    cfg_ci = '0; cfg_co = '0; cfg_pix = '0; cfg_base = '0;
    repeat (3) @(negedge clk);
    chk("rst_waddr", 64'(waddr), 64'(0));
    chk("rst_valid", 64'(waddr_valid), 64'(0));
    chk("rst_last", 64'(waddr_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
`ifdef CONV_WADDR_STALL_CNT_EN
    chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      run_cfg(tbl[t], 1'b0, beats, last_a);
      chk("tbl_beats", 64'(beats), 64'(tbl[t].exp_beats));
      chk("tbl_last_addr", 64'(last_a), 64'(tbl[t].exp_last_addr));
    end

    for (int r = 0; r < 4; r++) begin
      rv.ci = CFG_W'($urandom_range(0, 1));
      rv.co = CFG_W'($urandom_range(0, 3));
      rv.pix = PIX_W'($urandom_range(0, 3));
      rv.base = ADDR_W'($urandom);
      rv.stall_beat = -1; rv.stall_len = 0; rv.start_beat = 3;
      rv.exp_beats = (int'(rv.co) + 1) * (int'(rv.pix) + 1) * (int'(rv.ci) + 1) * CI_UNIT * VEC_LEN;
      rv.exp_last_addr = '0;
      run_cfg(rv, 1'b1, beats, last_a);
      chk("rnd_beats", 64'(beats), 64'(rv.exp_beats));
    end

    // Abort at beat 50 with ready held high.
    build_model(0, 1, 1, 26'h0000100);
    cfg_ci = 2'd0; cfg_co = 2'd1; cfg_pix = 9'd1; cfg_base = 26'h0000100;
    waddr_ready = 1'b1; start_conv = 1'b1;
    @(negedge clk);
    start_conv = 1'b0;
    for (int b = 0; b < 50; b++) begin
      chk("abort_pre_addr", 64'(waddr), 64'(exp_addr[b]));
      @(negedge clk);
    end
    chk("abort_beat50_addr", 64'(waddr), 64'(26'h0000132));
    chk("abort_beat50_valid", 64'(waddr_valid), 64'(1));
    end_conv = 1'b1;
    @(negedge clk);
    end_conv = 1'b0;
    chk("abort_valid", 64'(waddr_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_last", 64'(waddr_last), 64'(0));
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_done", 64'(done), 64'(0));
      chk("abort_idle_valid", 64'(waddr_valid), 64'(0));
      @(negedge clk);
    end

    // Fresh start at a new base; end_conv in IDLE must not block it.
    build_model(0, 0, 0, 26'h0002000);
    cfg_base = 26'h0002000; cfg_co = 2'd0; cfg_pix = 9'd0;
    start_conv = 1'b1; end_conv = 1'b1;
    @(negedge clk);
    start_conv = 1'b0; end_conv = 1'b0;
    chk("restart_first_addr", 64'(waddr), 64'(26'h0002000));
    for (int b = 0; b < 30; b++) begin
      chk("restart_valid", 64'(waddr_valid), 64'(1));
      chk("restart_addr", 64'(waddr), 64'(exp_addr[b]));
      @(negedge clk);
    end

    // Reset in the middle of a run.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_waddr", 64'(waddr), 64'(0));
    chk("midrst_valid", 64'(waddr_valid), 64'(0));
    chk("midrst_last", 64'(waddr_last), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
`ifdef CONV_WADDR_STALL_CNT_EN
    chk("midrst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    @(negedge clk);
    chk("midrst_stays_idle", 64'(waddr_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
